// File: rtl/neuron_pkg.sv
// Shared fixed-point format for the pre-activation MAC and the tanh PLA,
// so both ends of the datapath agree on widths and the requantization shift.
package neuron_pkg;

  localparam int W_DATA    = 8;
  localparam int X_F       = 5;
  localparam int W_F       = 6;
  localparam int W_ACC     = 24;
  localparam int MAX_TERMS = 16;
  localparam int W_OUT     = 8;
  localparam int OUT_I     = 4;
  localparam int OUT_F     = W_OUT - OUT_I;
  localparam int SH        = X_F + W_F - OUT_F;

  localparam logic [1:0] ST_ACC    = 2'd0;
  localparam logic [1:0] ST_FLUSH1 = 2'd1;
  localparam logic [1:0] ST_FLUSH2 = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  // Right shift that maps a product of (xf + wf) fractional bits onto the output format.
  function automatic int requant_shift(input int xf, input int wf, input int w_out, input int out_i);
    return xf + wf - (w_out - out_i);
  endfunction

endpackage

// File: rtl/preact_requant.sv
// Combinational requantizer: arithmetic shift of the accumulator to the output
// format, optional round-half-up (PREACT_ROUND_EN), then signed saturation.
module preact_requant
  import neuron_pkg::*;
#(
  parameter int ACC_W = W_ACC,
  parameter int OUT_W = W_OUT,
  parameter int SHIFT = SH
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic [OUT_W-1:0]        data,
  output logic                    sat
);

  if (SHIFT < 0) begin : g_bad_shift
    $error("preact_requant: negative requantization shift");
  end

  localparam logic signed [ACC_W:0] MAX_V = (ACC_W+1)'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] MIN_V = ~MAX_V;

  logic signed [ACC_W:0] ext;
  logic signed [ACC_W:0] r;

  assign ext = {acc[ACC_W-1], acc};

`ifdef PREACT_ROUND_EN
  localparam logic signed [ACC_W:0] RND = (ACC_W+1)'((SHIFT > 0) ? (1 << (SHIFT - 1)) : 0);
  // One guard bit keeps the rounding add from wrapping at the positive extreme.
  assign r = (ext + RND) >>> SHIFT;
`else
  assign r = ext >>> SHIFT;
`endif

  // Clip to the signed output range and flag any clipping.
  always_comb begin
    data = r[OUT_W-1:0];
    sat  = 1'b0;
    if (r > MAX_V) begin
      data = MAX_V[OUT_W-1:0];
      sat  = 1'b1;
    end else if (r < MIN_V) begin
      data = MIN_V[OUT_W-1:0];
      sat  = 1'b1;
    end else begin
      data = r[OUT_W-1:0];
      sat  = 1'b0;
    end
  end

endmodule

// File: rtl/preact_mac_stream.sv
// Streaming dot-product (bias + sum x*w) feeding the tanh PLA, with a
// valid/ready result port. Define PREACT_ROUND_EN for round-half-up requant.
module preact_mac_stream
  import neuron_pkg::*;
#(
  parameter int W_DATA    = neuron_pkg::W_DATA,
  parameter int X_F       = neuron_pkg::X_F,
  parameter int W_F       = neuron_pkg::W_F,
  parameter int W_ACC     = neuron_pkg::W_ACC,
  parameter int MAX_TERMS = neuron_pkg::MAX_TERMS,
  parameter int W_OUT     = neuron_pkg::W_OUT,
  parameter int OUT_I     = neuron_pkg::OUT_I
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W_DATA-1:0] in_x,
  input  logic [W_DATA-1:0] in_w,
  input  logic [W_ACC-1:0]  in_bias,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W_OUT-1:0]  out_data,
  output logic              out_sat,
  output logic              out_len_err
);

  localparam int CW    = (MAX_TERMS > 1) ? $clog2(MAX_TERMS) : 1;
  localparam int SHIFT = requant_shift(X_F, W_F, W_OUT, OUT_I);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_TERMS - 1);

  if (W_ACC < 2 * W_DATA + CW) begin : g_bad_acc
    $error("preact_mac_stream: accumulator too narrow for MAX_TERMS products");
  end

  logic [1:0]              state;
  logic [1:0]              state_nx;
  logic [CW-1:0]           count;
  logic                    ready_r;
  logic [W_ACC-1:0]        prod;
  logic                    prod_v;
  logic                    first;
  logic [W_ACC-1:0]        bias_r;
  logic [W_ACC-1:0]        acc;
  logic                    len_err_pend;
  logic signed [2*W_DATA-1:0] mult;
  logic                    fire;
  logic                    beat_last;
  logic [W_OUT-1:0]        rq_data;
  logic                    rq_sat;

  assign mult      = $signed(in_x) * $signed(in_w);
  assign fire      = in_valid & ready_r;
  assign beat_last = in_last | (count == LAST_CNT);
  assign in_ready  = ready_r;

  // Next-state decode for the accumulate / flush / hold sequence.
  always_comb begin
    state_nx = state;
    case (state)
      ST_ACC:    if (fire & beat_last) state_nx = ST_FLUSH1; else state_nx = ST_ACC;
      ST_FLUSH1: state_nx = ST_FLUSH2;
      ST_FLUSH2: state_nx = ST_HOLD;
      ST_HOLD:   if (out_ready) state_nx = ST_ACC; else state_nx = ST_HOLD;
      default:   state_nx = ST_ACC;
    endcase
  end

  // State register; ready is registered from the next state so it drops right after the last beat.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_ACC;
      ready_r <= 1'b0;
    end else begin
      state   <= state_nx;
      ready_r <= (state_nx == ST_ACC);
    end
  end

  // Product pipeline, accumulator and held result.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count        <= '0;
      prod         <= '0;
      prod_v       <= 1'b0;
      first        <= 1'b0;
      bias_r       <= '0;
      acc          <= '0;
      len_err_pend <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_sat      <= 1'b0;
      out_len_err  <= 1'b0;
    end else begin
      prod_v <= fire;
      if (fire) begin
        prod  <= {{(W_ACC - 2 * W_DATA){mult[2*W_DATA-1]}}, mult};
        first <= (count == '0);
        count <= count + CW'(1);
        if (count == '0) begin
          bias_r <= in_bias;
        end
        if (beat_last) begin
          len_err_pend <= ~in_last;
        end
      end
      // The first product of a vector replaces the old sum instead of adding to it.
      if (prod_v) begin
        acc <= first ? (bias_r + prod) : (acc + prod);
      end
      if (state == ST_FLUSH2) begin
        out_data    <= rq_data;
        out_sat     <= rq_sat;
        out_len_err <= len_err_pend;
        out_valid   <= 1'b1;
      end else if ((state == ST_HOLD) && out_ready) begin
        out_valid <= 1'b0;
        count     <= '0;
      end
    end
  end

  preact_requant #(
    .ACC_W (W_ACC),
    .OUT_W (W_OUT),
    .SHIFT (SHIFT)
  ) u_requant (
    .acc  (acc),
    .data (rq_data),
    .sat  (rq_sat)
  );

endmodule

// File: tb/tb_preact_mac_stream.sv
// Directed bench for preact_mac_stream: hand-computed vectors covering bias,
// forced last, saturation, rounding mode, backpressure and mid-vector reset.
module tb_preact_mac_stream;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_x = 8'h00;
  logic [7:0]  in_w = 8'h00;
  logic [23:0] in_bias = 24'h0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_sat;
  logic        out_len_err;

  int checks = 0;
  int errors = 0;
  int lat;
  bit ready_low;

  always #5 clock = ~clock;

  preact_mac_stream dut (
    .clock       (clock),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_w        (in_w),
    .in_bias     (in_bias),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_sat     (out_sat),
    .out_len_err (out_len_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Drive n beats, then count edges until out_valid; ready_low stays 1 only if in_ready never rose meanwhile.
  task automatic send_vector(input int n, input logic [7:0] x, input logic [7:0] w,
                             input logic [23:0] bias, input bit use_last,
                             output int latency, output bit rdy_low);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      in_valid = 1'b1;
      in_x     = x;
      in_w     = w;
      in_bias  = bias;
      in_last  = use_last && (i == n - 1);
      for (int g = 0; g < 20 && !in_ready; g++) @(negedge clock);
      @(posedge clock);
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    latency  = 0;
    rdy_low  = 1'b1;
    while (!out_valid && latency < 20) begin
      if (in_ready) rdy_low = 1'b0;
      @(posedge clock);
      #1;
      latency++;
    end
  endtask

  task automatic take_result(input string tag, input logic [7:0] d, input logic s, input logic e);
    @(negedge clock);
    check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check_eq({tag, "_data"}, {24'd0, out_data}, {24'd0, d});
    check_eq({tag, "_sat"}, {31'd0, out_sat}, {31'd0, s});
    check_eq({tag, "_lenerr"}, {31'd0, out_len_err}, {31'd0, e});
    check_eq({tag, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    check_eq({tag, "_drop_valid"}, {31'd0, out_valid}, 32'd0);
    @(negedge clock);
    check_eq({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #12;
    check_eq("rst_ready", {31'd0, in_ready}, 32'd0);
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_data", {24'd0, out_data}, 32'd0);
    check_eq("rst_sat", {31'd0, out_sat}, 32'd0);
    check_eq("rst_lenerr", {31'd0, out_len_err}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // 1.0 * 0.5 = 0.5 -> 0x08
    send_vector(1, 8'd32, 8'd32, 24'd0, 1'b1, lat, ready_low);
    check_eq("one_latency", lat, 32'd2);
    take_result("one", 8'h08, 1'b0, 1'b0);

    // 4 * 0.5 + 1.0 = 3.0 -> 0x30
    send_vector(4, 8'd32, 8'd32, 24'd2048, 1'b1, lat, ready_low);
    check_eq("bias1_latency", lat, 32'd2);
    check_eq("bias1_ready_low", {31'd0, ready_low}, 32'd1);
    take_result("bias1", 8'h30, 1'b0, 1'b0);

    // 4 * 0.5 + 0.5 = 2.5 -> 0x28
    send_vector(4, 8'd32, 8'd32, 24'd1024, 1'b1, lat, ready_low);
    take_result("bias05", 8'h28, 1'b0, 1'b0);

    // 16 * 127*127 = 258064 >> 7 = 2016 -> clip high, forced last
    send_vector(16, 8'd127, 8'd127, 24'd0, 1'b0, lat, ready_low);
    check_eq("forced_latency", lat, 32'd2);
    take_result("forced", 8'h7F, 1'b1, 1'b1);

    // 4 * (-8192) = -32768 >> 7 = -256 -> clip low
    send_vector(4, 8'h80, 8'h40, 24'd0, 1'b1, lat, ready_low);
    take_result("neg_sat", 8'h80, 1'b1, 1'b0);
    // -8192 >> 7 = -64 = -4.0
    send_vector(1, 8'h80, 8'h40, 24'd0, 1'b1, lat, ready_low);
    take_result("neg_one", 8'hC0, 1'b0, 1'b0);

    // 64 is exactly half an output LSB
    send_vector(1, 8'd64, 8'd1, 24'd0, 1'b1, lat, ready_low);
`ifdef PREACT_ROUND_EN
    take_result("rnd_pos", 8'h01, 1'b0, 1'b0);
`else
    take_result("rnd_pos", 8'h00, 1'b0, 1'b0);
`endif
    send_vector(1, 8'hC0, 8'd1, 24'd0, 1'b1, lat, ready_low);
`ifdef PREACT_ROUND_EN
    take_result("rnd_neg", 8'h00, 1'b0, 1'b0);
`else
    take_result("rnd_neg", 8'hFF, 1'b0, 1'b0);
`endif

    // Backpressure: result must stay put while out_ready is low
    send_vector(1, 8'd32, 8'd32, 24'd0, 1'b1, lat, ready_low);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check_eq("stall_valid", {31'd0, out_valid}, 32'd1);
      check_eq("stall_data", {24'd0, out_data}, 32'h08);
    end
    take_result("stall", 8'h08, 1'b0, 1'b0);

    // Two beats of a vector, then reset; the partial sum must be discarded
    @(negedge clock);
    in_valid = 1'b1;
    in_x     = 8'd127;
    in_w     = 8'd127;
    in_bias  = 24'd4096;
    in_last  = 1'b0;
    repeat (2) @(negedge clock);
    in_valid = 1'b0;
    resetn   = 1'b0;
    #1;
    check_eq("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mid_rst_data", {24'd0, out_data}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    send_vector(1, 8'd32, 8'd32, 24'd0, 1'b1, lat, ready_low);
    check_eq("post_rst_latency", lat, 32'd2);
    take_result("post_rst", 8'h08, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
